// File: rtl/br_fifo_credit_pkg.sv
// Shared types for the credit-based FIFO push adapter.
package br_fifo_credit_pkg;

  typedef enum logic {
    INIT   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/br_credit_counter.sv
// Saturating up/down credit counter with a sticky overflow flag.
module br_credit_counter #(
  parameter int MaxCredit = 2,
  localparam int CW = $clog2(MaxCredit + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          incr,
  input  logic          decr,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  output logic [CW-1:0] value,
  output logic          overflow
);

  localparam logic [CW-1:0] MaxV = CW'(MaxCredit);

  logic [CW-1:0] value_reg, value_next, base;
  logic          overflow_reg, overflow_next, sat;

  // The load path still accepts a concurrent increment, so an early return is not lost.
  always_comb begin
    base          = load ? load_value : value_reg;
    sat           = incr && !decr && (base == MaxV);
    value_next    = base;
    overflow_next = overflow_reg | sat;
    if (incr && !decr && !sat) begin
      value_next = base + CW'(1);
    end else if (decr && !incr) begin
      value_next = base - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      value_reg    <= value_next;
      overflow_reg <= overflow_next;
    end
  end

  assign value    = value_reg;
  assign overflow = overflow_reg;

endmodule

// File: rtl/br_fifo_credit_push_adapter.sv
// Credit-gated push adapter in front of a non-backpressuring FIFO.
// Define BR_FIFO_CREDIT_REG_OUT_EN to register the FIFO push outputs (1-cycle latency).
module br_fifo_credit_push_adapter
  import br_fifo_credit_pkg::*;
#(
  parameter int Width = 1,
  parameter int MaxCredit = 2,
  localparam int CreditWidth = $clog2(MaxCredit + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   push_ready,
  input  logic                   push_valid,
  input  logic [Width-1:0]       push_data,
  input  logic [CreditWidth-1:0] credit_initial,
  input  logic [CreditWidth-1:0] credit_withhold,
  output logic                   fifo_push_valid,
  output logic [Width-1:0]       fifo_push_data,
  input  logic                   fifo_credit_return,
  output logic [CreditWidth-1:0] credit_count,
  output logic [CreditWidth-1:0] credit_available,
  output logic                   credit_overflow
);

  localparam logic [CreditWidth-1:0] MaxCreditV = CreditWidth'(MaxCredit);

  state_e                 state_reg, state_next;
  logic                   load;
  logic                   push;
  logic [CreditWidth-1:0] load_value;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= INIT;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = ACTIVE;
  end

  always_comb begin
    load       = (state_reg == INIT);
    push_ready = (state_reg == ACTIVE) && (credit_available != '0);
  end

  assign push             = push_valid && push_ready;
  assign load_value       = (credit_initial > MaxCreditV) ? MaxCreditV : credit_initial;
  assign credit_available = (credit_count > credit_withhold) ? (credit_count - credit_withhold) : '0;

  br_credit_counter #(
    .MaxCredit(MaxCredit)
  ) u_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .incr      (fifo_credit_return),
    .decr      (push),
    .load      (load),
    .load_value(load_value),
    .value     (credit_count),
    .overflow  (credit_overflow)
  );

`ifdef BR_FIFO_CREDIT_REG_OUT_EN
  logic             valid_reg;
  logic [Width-1:0] data_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else begin
      valid_reg <= push;
      if (push) begin
        data_reg <= push_data;
      end
    end
  end

  assign fifo_push_valid = valid_reg;
  assign fifo_push_data  = data_reg;
`else
  // Holding the last pushed word keeps the data output quiet between pushes.
  logic [Width-1:0] data_hold_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_hold_reg <= '0;
    end else if (push) begin
      data_hold_reg <= push_data;
    end
  end

  assign fifo_push_valid = push;
  assign fifo_push_data  = push ? push_data : data_hold_reg;
`endif

`ifndef SYNTHESIS
  a_no_push_without_credit : assert property (@(posedge clk) disable iff (!rst_n)
    push |-> (credit_available != '0));

  a_withhold_stable_in_init : assert property (@(posedge clk) disable iff (!rst_n)
    (state_reg == INIT) |=> $stable(credit_withhold));
`endif

endmodule

// File: tb/tb_br_fifo_credit_push_adapter.sv
// Randomized and directed bench for br_fifo_credit_push_adapter against a credit-accounting model.
module tb_br_fifo_credit_push_adapter;

  localparam int W   = 8;
  localparam int MC  = 4;
  localparam int CWt = $clog2(MC + 1);

  logic           clk = 1'b0;
  logic           rst_n;
  logic           push_ready;
  logic           push_valid;
  logic [W-1:0]   push_data;
  logic [CWt-1:0] credit_initial;
  logic [CWt-1:0] credit_withhold;
  logic           fifo_push_valid;
  logic [W-1:0]   fifo_push_data;
  logic           fifo_credit_return;
  logic [CWt-1:0] credit_count;
  logic [CWt-1:0] credit_available;
  logic           credit_overflow;

  br_fifo_credit_push_adapter #(.Width(W), .MaxCredit(MC)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .push_ready        (push_ready),
    .push_valid        (push_valid),
    .push_data         (push_data),
    .credit_initial    (credit_initial),
    .credit_withhold   (credit_withhold),
    .fifo_push_valid   (fifo_push_valid),
    .fifo_push_data    (fifo_push_data),
    .fifo_credit_return(fifo_credit_return),
    .credit_count      (credit_count),
    .credit_available  (credit_available),
    .credit_overflow   (credit_overflow)
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model: plain integer credit pool and last-transfer bookkeeping.
  int m_credits       = 0;
  bit m_ovf           = 0;
  bit m_active        = 0;
  int m_active_cycles = 0;
  bit m_prev_push     = 0;
  int m_last_data     = 0;
  bit cur_push        = 0;
  int n_fifo_pushes   = 0;

  task automatic check(input string tag, input int observed, input int expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic check_outputs();
    int avail, exp_ready, exp_valid, exp_data, exp_count, exp_ovf;
    if (!rst_n) begin
      avail = 0; exp_ready = 0; cur_push = 0; exp_valid = 0; exp_data = 0;
      exp_count = 0; exp_ovf = 0;
    end else begin
      exp_count = m_credits;
      exp_ovf   = m_ovf;
      avail     = (m_credits > int'(credit_withhold)) ? m_credits - int'(credit_withhold) : 0;
      exp_ready = (m_active && avail != 0) ? 1 : 0;
      cur_push  = push_valid && (exp_ready != 0);
`ifdef BR_FIFO_CREDIT_REG_OUT_EN
      exp_valid = m_prev_push;
      exp_data  = m_last_data;
`else
      exp_valid = cur_push;
      exp_data  = cur_push ? int'(push_data) : m_last_data;
`endif
    end
    check("push_ready", int'(push_ready), exp_ready);
    check("credit_count", int'(credit_count), exp_count);
    check("credit_available", int'(credit_available), avail);
    check("credit_overflow", int'(credit_overflow), exp_ovf);
    check("fifo_push_valid", int'(fifo_push_valid), exp_valid);
    check("fifo_push_data", int'(fifo_push_data), exp_data);
    if (fifo_push_valid) n_fifo_pushes++;
  endtask

  task automatic model_advance();
    int c;
    if (!rst_n) begin
      m_credits = 0; m_ovf = 0; m_active = 0; m_active_cycles = 0;
      m_prev_push = 0; m_last_data = 0;
    end else if (!m_active) begin
      c = (int'(credit_initial) > MC) ? MC : int'(credit_initial);
      c += int'(fifo_credit_return);
      if (c > MC) begin
        c = MC;
        m_ovf = 1;
      end
      m_credits   = c;
      m_active    = 1;
      m_prev_push = 0;
    end else begin
      if (fifo_credit_return && !cur_push && m_credits == MC) m_ovf = 1;
      else m_credits += int'(fifo_credit_return) - int'(cur_push);
      m_prev_push = cur_push;
      if (cur_push) m_last_data = int'(push_data);
      m_active_cycles++;
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles, input int init_val, input int withhold_val);
    rst_n = 1'b0;
    credit_initial  = CWt'(init_val);
    credit_withhold = CWt'(withhold_val);
    repeat (cycles) cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; push_valid = 1'b0; push_data = '0; credit_initial = '0;
    credit_withhold = '0; fifo_credit_return = 1'b0;
    @(posedge clk); #1;

    // Full initial credit, push held high, no returns: exactly MaxCredit pushes.
    push_valid = 1'b1;
    do_reset(3, 4, 0);
    n_fifo_pushes = 0;
    for (int i = 0; i < 9; i++) begin
      push_data = W'(8'h40 + i);
      cycle();
    end
    check("exhaust_push_total", n_fifo_pushes, 4);
    check("exhaust_count", int'(credit_count), 0);

    // Single return from empty re-opens ready on the next cycle.
    push_valid = 1'b0; fifo_credit_return = 1'b1;
    cycle();
    fifo_credit_return = 1'b0;
    cycle();
    check("return_avail", int'(credit_available), 1);

    // Reach two credits, then push and return together for ten cycles.
    fifo_credit_return = 1'b1;
    cycle();
    push_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_data = W'(i);
      cycle();
    end
    push_valid = 1'b0; fifo_credit_return = 1'b0;
    cycle();
    check("steady_count", int'(credit_count), 2);

    // Return into a full pool raises the sticky overflow.
    fifo_credit_return = 1'b1;
    repeat (3) cycle();
    fifo_credit_return = 1'b0;
    repeat (3) cycle();
    check("overflow_sticky", int'(credit_overflow), 1);

    // Reset in the middle of pushing, then restart.
    push_valid = 1'b1;
    push_data = 8'hA5; cycle();
    push_data = 8'h5A; cycle();
    push_valid = 1'b0;
    do_reset(2, 3, 0);
    cycle();
    cycle();
    check("restart_count", int'(credit_count), 3);
    check("restart_overflow", int'(credit_overflow), 0);

    // Withholding leaves a single spendable credit.
    do_reset(2, 4, 3);
    push_valid = 1'b1;
    n_fifo_pushes = 0;
    for (int i = 0; i < 7; i++) begin
      push_data = W'(8'hC0 + i);
      cycle();
    end
    check("withhold_push_total", n_fifo_pushes, 1);
    push_valid = 1'b0;
    credit_withhold = '0;
    cycle();

    // Randomized traffic with occasional resets and withhold changes.
    for (int i = 0; i < 800; i++) begin
      push_valid         = ($urandom_range(0, 3) != 0);
      fifo_credit_return = ($urandom_range(0, 2) == 0);
      push_data          = W'($urandom);
      credit_initial     = CWt'($urandom_range(0, 7));
      if (rst_n && m_active_cycles >= 2 && $urandom_range(0, 15) == 0)
        credit_withhold = CWt'($urandom_range(0, 5));
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 99) == 0) rst_n = 1'b0;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
